// File: rtl/fb_wr_arb.sv
// Frame buffer write-port controller: round-robin share of the BRAM write
// port between two requesters plus a full-memory fill sweep.
module fb_wr_arb #(
    parameter int dwidth     = 8,
    parameter int addr_width = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_start,
    input  logic [dwidth-1:0]     clear_val,
    output logic                  clear_busy,
    input  logic                  req0_valid,
    input  logic [addr_width-1:0] req0_addr,
    input  logic [dwidth-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [addr_width-1:0] req1_addr,
    input  logic [dwidth-1:0]     req1_data,
    output logic                  req1_ready,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_waddr,
    output logic [dwidth-1:0]     mem_wdata
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] cnt_q, cnt_d;
    logic [dwidth-1:0]     fill_q, fill_d;
    logic                  last_q, last_d;

    logic grant0;
    logic grant1;

    // Round-robin: on a tie, the requester not granted last time wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_q);
        grant1 = req1_valid & (~req0_valid | ~last_q);
    end

    // Next-state and write-port muxing; reset forces every output low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        last_d     = last_q;
        clear_busy = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        if (!reset) begin
            unique case (state_q)
                ARB: begin
                    if (clear_start) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                        fill_d  = clear_val;
                    end else if (grant0) begin
                        req0_ready = 1'b1;
                        mem_we     = 1'b1;
                        mem_waddr  = req0_addr;
                        mem_wdata  = req0_data;
                        last_d     = 1'b0;
                    end else if (grant1) begin
                        req1_ready = 1'b1;
                        mem_we     = 1'b1;
                        mem_waddr  = req1_addr;
                        mem_wdata  = req1_data;
                        last_d     = 1'b1;
                    end
                end
                CLEAR: begin
                    clear_busy = 1'b1;
                    mem_we     = 1'b1;
                    mem_waddr  = cnt_q;
                    mem_wdata  = fill_q;
                    if (cnt_q == {addr_width{1'b1}}) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end

    // State registers with synchronous reset; last=1 lets req0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            cnt_q   <= '0;
            fill_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_fb_wr_arb.sv
// Directed testbench for fb_wr_arb with a 16-word memory.
// Inputs change after the falling edge; outputs are checked 1ns later.
module tb_fb_wr_arb;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_val = '0;
    logic          clear_busy;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [3:0] st;
    int total = 0;
    int bad = 0;

    assign st = {req0_ready, req1_ready, mem_we, clear_busy};

    always #5 clk = ~clk;

    fb_wr_arb #(.dwidth(DW), .addr_width(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_start(clear_start),
        .clear_val  (clear_val),
        .clear_busy (clear_busy),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_start = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1;
        req0_addr = 4'h6;
        req0_data = 8'h66;
        #1;
        total++;
        if (st !== 4'b0000 || mem_waddr !== 4'h0 || mem_wdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_outs got st=%b a=%h d=%h exp st=0000 a=0 d=00",
                     st, mem_waddr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (st !== 4'b0000 || mem_waddr !== 4'h0 || mem_wdata !== 8'h00) begin
                bad++;
                $display("FAIL idle[%0d] got st=%b a=%h d=%h exp st=0000 a=0 d=00",
                         i, st, mem_waddr, mem_wdata);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr = 4'h3;
        req0_data = 8'hA5;
        #1;
        total++;
        if (st !== 4'b1010 || mem_waddr !== 4'h3 || mem_wdata !== 8'hA5) begin
            bad++;
            $display("FAIL single got st=%b a=%h d=%h exp st=1010 a=3 d=a5",
                     st, mem_waddr, mem_wdata);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        total++;
        if (st !== 4'b0000) begin
            bad++;
            $display("FAIL single_drop got st=%b exp 0000", st);
        end
    endtask

    task automatic test_contention();
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_rdy;
        logic [3:0] exp_a;
        logic [7:0] exp_d;
        do_reset();
        d0 = 8'h11;
        d1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req0_valid = 1'b1;
            req0_addr = 4'h1;
            req0_data = d0;
            req1_valid = 1'b1;
            req1_addr = 4'h2;
            req1_data = d1;
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_a = (i % 2 == 0) ? 4'h1 : 4'h2;
            exp_d = (i % 2 == 0) ? d0 : d1;
            total++;
            if ({req0_ready, req1_ready} !== exp_rdy || mem_we !== 1'b1 ||
                mem_waddr !== exp_a || mem_wdata !== exp_d) begin
                bad++;
                $display("FAIL contend[%0d] got rdy=%b we=%b a=%h d=%h exp rdy=%b we=1 a=%h d=%h",
                         i, {req0_ready, req1_ready}, mem_we, mem_waddr, mem_wdata,
                         exp_rdy, exp_a, exp_d);
            end
            if (i % 2 == 0) d0 = d0 + 8'h01;
            else d1 = d1 + 8'h01;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_clear();
        @(negedge clk);
        req1_valid = 1'b1;
        req1_addr = 4'h5;
        req1_data = 8'h55;
        clear_start = 1'b1;
        clear_val = 8'h7E;
        #1;
        total++;
        if (st !== 4'b0000) begin
            bad++;
            $display("FAIL clr_start got st=%b exp 0000", st);
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            clear_val = 8'h00;
            #1;
            total++;
            if (st !== 4'b0011 || mem_waddr !== 4'(i) || mem_wdata !== 8'h7E) begin
                bad++;
                $display("FAIL clr_sweep[%0d] got st=%b a=%h d=%h exp st=0011 a=%h d=7e",
                         i, st, mem_waddr, mem_wdata, 4'(i));
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (st !== 4'b0110 || mem_waddr !== 4'h5 || mem_wdata !== 8'h55) begin
            bad++;
            $display("FAIL clr_resume got st=%b a=%h d=%h exp st=0110 a=5 d=55",
                     st, mem_waddr, mem_wdata);
        end
        @(negedge clk);
        req1_valid = 1'b0;
    endtask

    task automatic test_start_and_req();
        int writes;
        writes = 0;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr = 4'h9;
        req0_data = 8'h99;
        clear_start = 1'b1;
        clear_val = 8'h3C;
        #1;
        total++;
        if (st !== 4'b0000) begin
            bad++;
            $display("FAIL sr_start got st=%b exp 0000", st);
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            clear_start = (i == 5);
            clear_val = (i == 5) ? 8'hFF : 8'h00;
            #1;
            if (mem_we === 1'b1) writes++;
            total++;
            if (st !== 4'b0011 || mem_waddr !== 4'(i) || mem_wdata !== 8'h3C) begin
                bad++;
                $display("FAIL sr_sweep[%0d] got st=%b a=%h d=%h exp st=0011 a=%h d=3c",
                         i, st, mem_waddr, mem_wdata, 4'(i));
            end
        end
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        total++;
        if (writes != N) begin
            bad++;
            $display("FAIL sr_count got %0d exp %0d", writes, N);
        end
        total++;
        if (st !== 4'b1010 || mem_waddr !== 4'h9 || mem_wdata !== 8'h99) begin
            bad++;
            $display("FAIL sr_resume got st=%b a=%h d=%h exp st=1010 a=9 d=99",
                     st, mem_waddr, mem_wdata);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        total++;
        if (st !== 4'b0000) begin
            bad++;
            $display("FAIL sr_idle got st=%b exp 0000", st);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clear_start = 1'b1;
        clear_val = 8'h5A;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            #1;
            total++;
            if (st !== 4'b0011 || mem_waddr !== 4'(i) || mem_wdata !== 8'h5A) begin
                bad++;
                $display("FAIL rm_sweep[%0d] got st=%b a=%h d=%h exp st=0011 a=%h d=5a",
                         i, st, mem_waddr, mem_wdata, 4'(i));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (st !== 4'b0000 || mem_waddr !== 4'h0 || mem_wdata !== 8'h00) begin
            bad++;
            $display("FAIL rm_inreset got st=%b a=%h d=%h exp st=0000 a=0 d=00",
                     st, mem_waddr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (st !== 4'b0000) begin
            bad++;
            $display("FAIL rm_after got st=%b exp 0000", st);
        end
        @(negedge clk);
        clear_start = 1'b1;
        clear_val = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            #1;
            total++;
            if (st !== 4'b0011 || mem_waddr !== 4'(i) || mem_wdata !== 8'hC3) begin
                bad++;
                $display("FAIL rm_resweep[%0d] got st=%b a=%h d=%h exp st=0011 a=%h d=c3",
                         i, st, mem_waddr, mem_wdata, 4'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_clear();
        test_start_and_req();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
